// File: rtl/sort_agu_mlane.sv
// sort_agu_mlane: multi-lane address generation unit for the sort engine.
//
// Accepts up to LANE_NUM keys per beat, rebases each against cfg_key_base_i,
// drops out-of-range lanes, then issues the remaining lanes towards the SBU
// and the count-memory banks. Per issue cycle at most one lane per bank is
// issued; lanes carrying the same key as an issued lane fold into its
// increment instead of occupying another slot.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cfg_key_base_i        rebase value, sampled when a beat is accepted
//   agu_vld_i/agu_rdy_o   input beat handshake
//   agu_mask_i/agu_data_i per-lane key valid / keys (lane i at i*KEY_W)
//   out_vld_o/out_rdy_i   output vector handshake
//   out_mask_o            per-lane issue valid
//   agu2sbu_addr_o/id_o   rebased key split for the SBU tiles
//   agu2cnt_addr_o/bankid_o rebased key split for the count-memory banks
//   agu2cnt_inc_o         per-lane count increment
//   oor_pulse_o/oor_cnt_o out-of-range beat pulse / saturating drop count
module sort_agu_mlane #(
  parameter int SORT_FUC_MAX_NUM       = 1024,
  parameter int SORT_FUC_BK_NUM        = 4,
  parameter int SORT_PERF_SBU_TILE_NUM = 8,
  parameter int LANE_NUM               = 4,
  parameter int KEY_W                  = 16,
  parameter int DATA_W                 = $clog2(SORT_FUC_MAX_NUM),
  parameter int BK_W                   = $clog2(SORT_FUC_BK_NUM),
  parameter int CNT_ADDR_W             = DATA_W - BK_W,
  parameter int TILE_W                 = $clog2(SORT_PERF_SBU_TILE_NUM),
  parameter int SBU_ADDR_W             = DATA_W - TILE_W,
  parameter int INC_W                  = $clog2(LANE_NUM + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [KEY_W-1:0]                 cfg_key_base_i,
  input  logic                             agu_vld_i,
  output logic                             agu_rdy_o,
  input  logic [LANE_NUM-1:0]              agu_mask_i,
  input  logic [LANE_NUM*KEY_W-1:0]        agu_data_i,
  output logic                             out_vld_o,
  input  logic                             out_rdy_i,
  output logic [LANE_NUM-1:0]              out_mask_o,
  output logic [LANE_NUM*SBU_ADDR_W-1:0]   agu2sbu_addr_o,
  output logic [LANE_NUM*TILE_W-1:0]       agu2sbu_id_o,
  output logic [LANE_NUM*CNT_ADDR_W-1:0]   agu2cnt_addr_o,
  output logic [LANE_NUM*BK_W-1:0]         agu2cnt_bankid_o,
  output logic [LANE_NUM*INC_W-1:0]        agu2cnt_inc_o,
  output logic                             oor_pulse_o,
  output logic [15:0]                      oor_cnt_o
);

  logic [LANE_NUM-1:0] pend_mask;
  logic [DATA_W-1:0]   pend_key [LANE_NUM];

  logic [KEY_W:0]      diff     [LANE_NUM];
  logic [DATA_W-1:0]   in_key   [LANE_NUM];
  logic [LANE_NUM-1:0] in_ok, in_oor;
  logic [INC_W-1:0]    oor_num;
  logic [16:0]         oor_sum;

  logic [LANE_NUM-1:0] win, clr;
  logic [INC_W-1:0]    inc      [LANE_NUM];

  logic [LANE_NUM*SBU_ADDR_W-1:0] nxt_sbu_addr;
  logic [LANE_NUM*TILE_W-1:0]     nxt_sbu_id;
  logic [LANE_NUM*CNT_ADDR_W-1:0] nxt_cnt_addr;
  logic [LANE_NUM*BK_W-1:0]       nxt_cnt_bank;
  logic [LANE_NUM*INC_W-1:0]      nxt_cnt_inc;

  logic issue_en, acc;

  // Rebase: one extra bit so a key below the base shows up as negative.
  always_comb begin
    in_ok   = '0;
    in_oor  = '0;
    oor_num = '0;
    for (int unsigned i = 0; i < LANE_NUM; i++) begin
      diff[i]   = {1'b0, agu_data_i[i*KEY_W +: KEY_W]} - {1'b0, cfg_key_base_i};
      in_key[i] = diff[i][DATA_W-1:0];
      in_oor[i] = agu_mask_i[i] &
                  (diff[i][KEY_W] |
                   ({1'b0, diff[i][KEY_W-1:0]} >= (KEY_W+1)'(SORT_FUC_MAX_NUM)));
      in_ok[i]  = agu_mask_i[i] & ~in_oor[i];
      oor_num   = oor_num + INC_W'(in_oor[i]);
    end
    oor_sum = {1'b0, oor_cnt_o} + 17'(oor_num);
  end

  // Winner = lowest pending lane on its bank. Identical keys always share a
  // bank, so a lane merges only into the winner of its own bank.
  always_comb begin
    win = '0;
    clr = '0;
    for (int unsigned i = 0; i < LANE_NUM; i++) begin
      win[i] = pend_mask[i];
      for (int unsigned j = 0; j < i; j++)
        if (pend_mask[j] && (pend_key[j][BK_W-1:0] == pend_key[i][BK_W-1:0]))
          win[i] = 1'b0;
    end
    for (int unsigned i = 0; i < LANE_NUM; i++) begin
      clr[i] = win[i];
      for (int unsigned j = 0; j < i; j++)
        if (pend_mask[i] && win[j] && (pend_key[j] == pend_key[i]))
          clr[i] = 1'b1;
    end
  end

  // Increment counts the winner itself plus every later identical lane.
  always_comb begin
    for (int unsigned i = 0; i < LANE_NUM; i++) begin
      inc[i] = '0;
      if (win[i])
        for (int unsigned j = i; j < LANE_NUM; j++)
          if (pend_mask[j] && (pend_key[j] == pend_key[i]))
            inc[i] = inc[i] + INC_W'(1);
    end
  end

  always_comb begin
    nxt_sbu_addr = '0;
    nxt_sbu_id   = '0;
    nxt_cnt_addr = '0;
    nxt_cnt_bank = '0;
    nxt_cnt_inc  = '0;
    for (int unsigned i = 0; i < LANE_NUM; i++) begin
      if (win[i]) begin
        nxt_sbu_addr[i*SBU_ADDR_W +: SBU_ADDR_W] = pend_key[i][DATA_W-1:TILE_W];
        nxt_sbu_id[i*TILE_W +: TILE_W]           = pend_key[i][TILE_W-1:0];
        nxt_cnt_addr[i*CNT_ADDR_W +: CNT_ADDR_W] = pend_key[i][DATA_W-1:BK_W];
        nxt_cnt_bank[i*BK_W +: BK_W]             = pend_key[i][BK_W-1:0];
        nxt_cnt_inc[i*INC_W +: INC_W]            = inc[i];
      end
    end
  end

  assign issue_en  = ~out_vld_o | out_rdy_i;
  // A new beat may replace the pending one in the same cycle its last
  // lanes issue, which keeps conflict-free traffic bubble-free.
  assign agu_rdy_o = (pend_mask == '0) | (issue_en & (clr == pend_mask));
  assign acc       = agu_vld_i & agu_rdy_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_mask        <= '0;
      for (int unsigned i = 0; i < LANE_NUM; i++) pend_key[i] <= '0;
      out_vld_o        <= 1'b0;
      out_mask_o       <= '0;
      agu2sbu_addr_o   <= '0;
      agu2sbu_id_o     <= '0;
      agu2cnt_addr_o   <= '0;
      agu2cnt_bankid_o <= '0;
      agu2cnt_inc_o    <= '0;
      oor_pulse_o      <= 1'b0;
      oor_cnt_o        <= '0;
    end else begin
      if (acc) begin
        pend_mask <= in_ok;
        pend_key  <= in_key;
      end else if (issue_en) begin
        pend_mask <= pend_mask & ~clr;
      end
      if (issue_en) begin
        out_vld_o        <= |win;
        out_mask_o       <= win;
        agu2sbu_addr_o   <= nxt_sbu_addr;
        agu2sbu_id_o     <= nxt_sbu_id;
        agu2cnt_addr_o   <= nxt_cnt_addr;
        agu2cnt_bankid_o <= nxt_cnt_bank;
        agu2cnt_inc_o    <= nxt_cnt_inc;
      end
      oor_pulse_o <= acc & (|in_oor);
      if (acc)
        oor_cnt_o <= oor_sum[16] ? '1 : oor_sum[15:0];
    end
  end

endmodule

// File: tb/tb_sort_agu_mlane.sv
module tb_sort_agu_mlane;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] base = '0;
  logic        vld = 1'b0;
  logic        rdy;
  logic [3:0]  mask = '0;
  logic [63:0] data = '0;
  logic        ovld;
  logic        ordy = 1'b1;
  logic [3:0]  omask;
  logic [27:0] sbu_addr;
  logic [11:0] sbu_id;
  logic [31:0] cnt_addr;
  logic [7:0]  cnt_bank;
  logic [11:0] cnt_inc;
  logic        oor_pulse;
  logic [15:0] oor_cnt;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  sort_agu_mlane dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cfg_key_base_i   (base),
    .agu_vld_i        (vld),
    .agu_rdy_o        (rdy),
    .agu_mask_i       (mask),
    .agu_data_i       (data),
    .out_vld_o        (ovld),
    .out_rdy_i        (ordy),
    .out_mask_o       (omask),
    .agu2sbu_addr_o   (sbu_addr),
    .agu2sbu_id_o     (sbu_id),
    .agu2cnt_addr_o   (cnt_addr),
    .agu2cnt_bankid_o (cnt_bank),
    .agu2cnt_inc_o    (cnt_inc),
    .oor_pulse_o      (oor_pulse),
    .oor_cnt_o        (oor_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] m, input logic r);
    chk({tag, ".vld"}, 32'(ovld), 32'(v));
    chk({tag, ".mask"}, 32'(omask), 32'(m));
    chk({tag, ".rdy"}, 32'(rdy), 32'(r));
  endtask

  task automatic chk_lane(input string tag, input int l, input int ca, input int bk,
                          input int sa, input int id, input int inc);
    chk({tag, ".cnt_addr"}, 32'(cnt_addr[l*8 +: 8]), 32'(ca));
    chk({tag, ".bank"},     32'(cnt_bank[l*2 +: 2]), 32'(bk));
    chk({tag, ".sbu_addr"}, 32'(sbu_addr[l*7 +: 7]), 32'(sa));
    chk({tag, ".sbu_id"},   32'(sbu_id[l*3 +: 3]),   32'(id));
    chk({tag, ".inc"},      32'(cnt_inc[l*3 +: 3]),  32'(inc));
  endtask

  task automatic beat(input logic [15:0] b, input logic [3:0] m,
                      input logic [15:0] k0, input logic [15:0] k1,
                      input logic [15:0] k2, input logic [15:0] k3);
    base = b;
    mask = m;
    data = {k3, k2, k1, k0};
    vld  = 1'b1;
  endtask

  initial begin
    // reset
    tick();
    tick();
    chk_out("rst", 1'b0, 4'h0, 1'b1);
    chk("rst.oor_cnt", 32'(oor_cnt), 0);
    chk("rst.inc", 32'(cnt_inc), 0);
    rst = 1'b0;

    // 1: conflict-free {1,2,3,4}
    beat(16'd0, 4'hF, 16'd1, 16'd2, 16'd3, 16'd4);
    tick();
    vld = 1'b0;
    chk_out("t1.pend", 1'b0, 4'h0, 1'b1);
    tick();
    chk_out("t1.o", 1'b1, 4'hF, 1'b1);
    chk_lane("t1.l0", 0, 0, 1, 0, 1, 1);
    chk_lane("t1.l1", 1, 0, 2, 0, 2, 1);
    chk_lane("t1.l2", 2, 0, 3, 0, 3, 1);
    chk_lane("t1.l3", 3, 1, 0, 0, 4, 1);
    tick();
    chk_out("t1.end", 1'b0, 4'h0, 1'b1);

    // 2: all bank 0, distinct {0,4,8,12}
    beat(16'd0, 4'hF, 16'd0, 16'd4, 16'd8, 16'd12);
    tick();
    vld = 1'b0;
    chk_out("t2.pend", 1'b0, 4'h0, 1'b0);
    tick();
    chk_out("t2.c1", 1'b1, 4'h1, 1'b0);
    chk_lane("t2.c1.l0", 0, 0, 0, 0, 0, 1);
    tick();
    chk_out("t2.c2", 1'b1, 4'h2, 1'b0);
    chk_lane("t2.c2.l1", 1, 1, 0, 0, 4, 1);
    chk_lane("t2.c2.l0", 0, 0, 0, 0, 0, 0);
    tick();
    chk_out("t2.c3", 1'b1, 4'h4, 1'b1);
    chk_lane("t2.c3.l2", 2, 2, 0, 1, 0, 1);
    tick();
    chk_out("t2.c4", 1'b1, 4'h8, 1'b1);
    chk_lane("t2.c4.l3", 3, 3, 0, 1, 4, 1);
    tick();
    chk_out("t2.end", 1'b0, 4'h0, 1'b1);

    // 3: merge {5,5,5,9}
    beat(16'd0, 4'hF, 16'd5, 16'd5, 16'd5, 16'd9);
    tick();
    vld = 1'b0;
    chk_out("t3.pend", 1'b0, 4'h0, 1'b0);
    tick();
    chk_out("t3.c1", 1'b1, 4'h1, 1'b1);
    chk_lane("t3.c1.l0", 0, 1, 1, 0, 5, 3);
    tick();
    chk_out("t3.c2", 1'b1, 4'h8, 1'b1);
    chk_lane("t3.c2.l3", 3, 2, 1, 1, 1, 1);
    tick();
    chk_out("t3.end", 1'b0, 4'h0, 1'b1);

    // 4: base 100, out-of-range at both ends
    beat(16'd100, 4'hF, 16'd99, 16'd100, 16'd1123, 16'd1124);
    tick();
    vld = 1'b0;
    chk("t4.pulse", 32'(oor_pulse), 1);
    chk("t4.oor_cnt", 32'(oor_cnt), 2);
    chk_out("t4.pend", 1'b0, 4'h0, 1'b1);
    tick();
    chk("t4.pulse_off", 32'(oor_pulse), 0);
    chk_out("t4.o", 1'b1, 4'h6, 1'b1);
    chk_lane("t4.l1", 1, 0, 0, 0, 0, 1);
    chk_lane("t4.l2", 2, 255, 3, 127, 7, 1);
    chk_lane("t4.l0", 0, 0, 0, 0, 0, 0);
    tick();
    chk_out("t4.end", 1'b0, 4'h0, 1'b1);
    chk("t4.oor_hold", 32'(oor_cnt), 2);

    // 5: backpressure mid-conflict
    beat(16'd0, 4'hF, 16'd0, 16'd4, 16'd8, 16'd12);
    tick();
    vld = 1'b0;
    tick();
    chk_out("t5.c1", 1'b1, 4'h1, 1'b0);
    ordy = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk_out("t5.stall", 1'b1, 4'h1, 1'b0);
      chk_lane("t5.stall.l0", 0, 0, 0, 0, 0, 1);
    end
    ordy = 1'b1;
    tick();
    chk_out("t5.c2", 1'b1, 4'h2, 1'b0);
    chk_lane("t5.c2.l1", 1, 1, 0, 0, 4, 1);
    tick();
    chk_out("t5.c3", 1'b1, 4'h4, 1'b1);
    tick();
    chk_out("t5.c4", 1'b1, 4'h8, 1'b1);
    chk_lane("t5.c4.l3", 3, 3, 0, 1, 4, 1);
    tick();
    chk_out("t5.end", 1'b0, 4'h0, 1'b1);

    // 6: oor_cnt saturation, all four lanes out of range every beat
    beat(16'd0, 4'hF, 16'd2000, 16'd2000, 16'd2000, 16'd2000);
    for (int n = 0; n < 16383; n++) @(posedge clk);
    #1;
    chk("t6.cnt", 32'(oor_cnt), 65534);
    chk("t6.rdy", 32'(rdy), 1);
    tick();
    chk("t6.sat", 32'(oor_cnt), 65535);
    chk("t6.pulse", 32'(oor_pulse), 1);
    tick();
    vld = 1'b0;
    chk("t6.sat_hold", 32'(oor_cnt), 65535);
    chk("t6.no_out", 32'(ovld), 0);

    // 7: reset during a stall discards everything
    beat(16'd0, 4'hF, 16'd0, 16'd4, 16'd8, 16'd12);
    tick();
    vld = 1'b0;
    tick();
    chk_out("t7.c1", 1'b1, 4'h1, 1'b0);
    ordy = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_out("t7.rst", 1'b0, 4'h0, 1'b1);
    chk("t7.oor_cnt", 32'(oor_cnt), 0);
    rst  = 1'b0;
    ordy = 1'b1;
    tick();
    chk_out("t7.after1", 1'b0, 4'h0, 1'b1);
    tick();
    chk_out("t7.after2", 1'b0, 4'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
